// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a loaded pattern out on w, MSB of the
// active length first, with optional repetitions separated by idle gap cycles.
module seq_pattern_tx #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP     = 1
) (
  input  logic               clock,
  input  logic               reset_b,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [REP_W-1:0]   repeat_n,
  input  logic               abort,
  output logic               w,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [REP_W-1:0]   rep_left_q, rep_left_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               len_ok;
  logic [IDX_W-1:0]   idx_reload;

  // Handshake: start is a request honoured only in IDLE with a legal length;
  // busy stays high through SHIFT and GAP, and done pulses once on completion.
  assign len_ok     = (length != '0) && (32'(length) <= MAX_LEN);
  assign idx_reload = IDX_W'(len_q - LEN_W'(1));

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= S_IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      rep_left_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      rep_left_q <= rep_left_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    idx_d      = idx_q;
    rep_left_d = rep_left_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && len_ok) begin
          pat_d      = pattern;
          len_d      = length;
          idx_d      = IDX_W'(length - LEN_W'(1));
          rep_left_d = repeat_n;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IDX_W'(1);
        end else if (rep_left_q == '0) begin
          state_d = S_DONE;
        end else if (GAP == 0) begin
          idx_d      = idx_reload;
          rep_left_d = rep_left_q - REP_W'(1);
        end else begin
          gap_cnt_d  = GAP_W'(GAP - 1);
          rep_left_d = rep_left_q - REP_W'(1);
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == '0) begin
          idx_d   = idx_reload;
          state_d = S_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: decoded from registered state only.
  always_comb begin
    w     = 1'b0;
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    state = state_q;
    case (state_q)
      S_SHIFT: begin
        w     = pat_q[idx_q];
        valid = 1'b1;
        busy  = 1'b1;
      end
      S_GAP:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one task per scenario, inputs driven and
// outputs sampled on the falling clock edge.
module tb_seq_pattern_tx;

  logic       clock;
  logic       reset_b;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] length;
  logic [3:0] repeat_n;
  logic       abort;
  logic       w;
  logic       valid;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int n_compared;
  int n_mismatched;

  seq_pattern_tx #(
    .MAX_LEN(8), .LEN_W(4), .REP_W(4), .GAP(1)
  ) dut (
    .clock(clock), .reset_b(reset_b), .start(start), .pattern(pattern),
    .length(length), .repeat_n(repeat_n), .abort(abort), .w(w),
    .valid(valid), .busy(busy), .done(done), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset_b = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; length = '0; repeat_n = '0;
    repeat (2) @(negedge clock);
    n_compared++;
    if ({w, valid, busy, done, state} !== 6'b0) begin
      n_mismatched++;
      $display("FAIL reset_outputs: got w=%b valid=%b busy=%b done=%b state=%0d want all 0",
               w, valid, busy, done, state);
    end
    reset_b = 1'b1;
    @(negedge clock);
    n_compared++;
    if (state !== 2'd0) begin
      n_mismatched++;
      $display("FAIL reset_release_state: got %0d want 0", state);
    end
  endtask

  task automatic test_single_send();
    logic [3:0] exp_w;
    exp_w = 4'b1101;
    pattern = 8'b0000_1101; length = 4'd4; repeat_n = 4'd0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      start = 1'b0;
      n_compared++;
      if ({w, valid, busy, state} !== {exp_w[3-i], 1'b1, 1'b1, 2'd1}) begin
        n_mismatched++;
        $display("FAIL single_bit%0d: got w=%b valid=%b busy=%b state=%0d want w=%b valid=1 busy=1 state=1",
                 i, w, valid, busy, state, exp_w[3-i]);
      end
    end
    @(negedge clock);
    n_compared++;
    if ({done, busy, valid, w, state} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd3}) begin
      n_mismatched++;
      $display("FAIL single_done: got done=%b busy=%b valid=%b w=%b state=%0d want done=1 busy=0 valid=0 w=0 state=3",
               done, busy, valid, w, state);
    end
    @(negedge clock);
    n_compared++;
    if ({done, state} !== {1'b0, 2'd0}) begin
      n_mismatched++;
      $display("FAIL single_idle: got done=%b state=%0d want done=0 state=0", done, state);
    end
  endtask

  task automatic test_repeats();
    logic [13:0] exp_w;
    logic [13:0] exp_v;
    exp_w = 14'b11010110101101;
    exp_v = 14'b11110111101111;
    pattern = 8'b0000_1101; length = 4'd4; repeat_n = 4'd2; start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      start = 1'b0;
      n_compared++;
      if ({w, valid, busy, done, state} !==
          {exp_w[13-i], exp_v[13-i], 1'b1, 1'b0, (exp_v[13-i] ? 2'd1 : 2'd2)}) begin
        n_mismatched++;
        $display("FAIL repeat_cycle%0d: got w=%b valid=%b busy=%b done=%b state=%0d want w=%b valid=%b busy=1 done=0",
                 i, w, valid, busy, done, state, exp_w[13-i], exp_v[13-i]);
      end
    end
    @(negedge clock);
    n_compared++;
    if ({done, busy} !== 2'b10) begin
      n_mismatched++;
      $display("FAIL repeat_done: got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_compared++;
      if ({done, busy, state} !== {1'b0, 1'b0, 2'd0}) begin
        n_mismatched++;
        $display("FAIL repeat_after%0d: got done=%b busy=%b state=%0d want 0 0 0", i, done, busy, state);
      end
    end
  endtask

  task automatic test_illegal_length();
    logic [3:0] bad_len [2];
    bad_len[0] = 4'd0;
    bad_len[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      pattern = 8'hFF; length = bad_len[k]; repeat_n = 4'd0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        n_compared++;
        if ({busy, valid, done, state} !== {1'b0, 1'b0, 1'b0, 2'd0}) begin
          n_mismatched++;
          $display("FAIL illegal_len%0d_cycle%0d: got busy=%b valid=%b done=%b state=%0d want all 0",
                   bad_len[k], i, busy, valid, done, state);
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int done_cnt;
    done_cnt = 0;
    pattern = 8'b0000_1111; length = 4'd4; repeat_n = 4'd0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      start = (i == 1);
      if (i == 1) pattern = 8'h00;
      n_compared++;
      if ({w, valid} !== 2'b11) begin
        n_mismatched++;
        $display("FAIL busy_ignore_bit%0d: got w=%b valid=%b want w=1 valid=1", i, w, valid);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (done) done_cnt++;
      n_compared++;
      if (valid !== 1'b0) begin
        n_mismatched++;
        $display("FAIL busy_ignore_resend%0d: got valid=%b want 0", i, valid);
      end
    end
    n_compared++;
    if (done_cnt !== 1) begin
      n_mismatched++;
      $display("FAIL busy_ignore_done_count: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_abort();
    pattern = 8'hFF; length = 4'd8; repeat_n = 4'd0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      start = 1'b0;
      n_compared++;
      if (valid !== 1'b1) begin
        n_mismatched++;
        $display("FAIL abort_pre%0d: got valid=%b want 1", i, valid);
      end
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    n_compared++;
    if ({valid, busy, w, state} !== {1'b0, 1'b0, 1'b0, 2'd0}) begin
      n_mismatched++;
      $display("FAIL abort_stop: got valid=%b busy=%b w=%b state=%0d want 0 0 0 0", valid, busy, w, state);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_compared++;
      if ({done, valid} !== 2'b00) begin
        n_mismatched++;
        $display("FAIL abort_no_done%0d: got done=%b valid=%b want 0 0", i, done, valid);
      end
    end
  endtask

  task automatic test_abort_with_start();
    pattern = 8'b0000_0010; length = 4'd2; repeat_n = 4'd0; start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    n_compared++;
    if ({w, valid} !== 2'b11) begin
      n_mismatched++;
      $display("FAIL abort_start_bit0: got w=%b valid=%b want 1 1", w, valid);
    end
    @(negedge clock);
    n_compared++;
    if ({w, valid} !== 2'b01) begin
      n_mismatched++;
      $display("FAIL abort_start_bit1: got w=%b valid=%b want 0 1", w, valid);
    end
    @(negedge clock);
    n_compared++;
    if (done !== 1'b1) begin
      n_mismatched++;
      $display("FAIL abort_start_done: got %b want 1", done);
    end
    @(negedge clock);
  endtask

  task automatic test_max_repeat();
    int v_cnt;
    int b_cnt;
    int w_bad;
    bit seen_done;
    v_cnt = 0; b_cnt = 0; w_bad = 0; seen_done = 1'b0;
    pattern = 8'h01; length = 4'd1; repeat_n = 4'd15; start = 1'b1;
    for (int i = 0; i < 60 && !seen_done; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) seen_done = 1'b1;
      if (valid) v_cnt++;
      if (busy) b_cnt++;
      if (valid && w !== 1'b1) w_bad++;
    end
    n_compared++;
    if (!seen_done) begin
      n_mismatched++;
      $display("FAIL max_repeat_timeout: got no done within 60 cycles want done");
    end
    n_compared++;
    if (v_cnt !== 16 || b_cnt !== 31 || w_bad !== 0) begin
      n_mismatched++;
      $display("FAIL max_repeat_counts: got valid=%0d busy=%0d bad_w=%0d want 16 31 0", v_cnt, b_cnt, w_bad);
    end
    @(negedge clock);
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_p;
    int done_cnt;
    exp_p = 8'hA5;
    done_cnt = 0;
    pattern = exp_p; length = 4'd8; repeat_n = 4'd0; start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    #2 reset_b = 1'b0;
    #1;
    n_compared++;
    if ({w, valid, busy, state} !== {1'b0, 1'b0, 1'b0, 2'd0}) begin
      n_mismatched++;
      $display("FAIL async_reset_now: got w=%b valid=%b busy=%b state=%0d want 0 0 0 0", w, valid, busy, state);
    end
    @(negedge clock);
    reset_b = 1'b1;
    @(negedge clock);
    n_compared++;
    if ({done, valid} !== 2'b00) begin
      n_mismatched++;
      $display("FAIL async_reset_quiet: got done=%b valid=%b want 0 0", done, valid);
    end
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      start = 1'b0;
      n_compared++;
      if ({w, valid} !== {exp_p[7-i], 1'b1}) begin
        n_mismatched++;
        $display("FAIL async_resend_bit%0d: got w=%b valid=%b want w=%b valid=1", i, w, valid, exp_p[7-i]);
      end
    end
    @(negedge clock);
    n_compared++;
    if (done !== 1'b1) begin
      n_mismatched++;
      $display("FAIL async_resend_done: got %b want 1", done);
    end
    @(negedge clock);
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    test_reset();
    test_single_send();
    test_repeats();
    test_illegal_length();
    test_busy_ignore();
    test_abort();
    test_abort_with_start();
    test_max_repeat();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
